// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin credit with saturation guard, per-item stock,
// one-cycle dispense pulse and valid/ack change return. Optional inactivity timeout: VM_TIMEOUT_EN.
module vend_ctrl_multi #(
    parameter int                            NUM_ITEMS      = 4,
    parameter int                            CREDIT_W       = 8,
    parameter int                            STOCK_W        = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES    = {8'd100, 8'd75, 8'd50, 8'd25},
    parameter logic [4*CREDIT_W-1:0]         COIN_VALUES    = {8'd100, 8'd25, 8'd10, 8'd5},
    parameter int                            INIT_STOCK     = 3,
    parameter int                            TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_sel,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic                         cancel,
    input  logic                         restock_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
    input  logic                         change_ack,
    output logic                         vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amount,
    output logic                         coin_reject,
    output logic                         error,
    output logic [CREDIT_W-1:0]          credit,
    output logic [NUM_ITEMS-1:0]         sold_out,
    output logic [1:0]                   state
);

    // state    | meaning
    // IDLE     | no credit, waiting for the first coin
    // COLLECT  | accumulating credit, accepting selection/cancel
    // DISPENSE | single cycle, vend_valid asserted
    // CHANGE   | change_valid held until change_ack

    localparam int IDX_W = $clog2(NUM_ITEMS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t               state_q, state_n;
    logic [CREDIT_W-1:0]  credit_q, credit_n;
    logic [CREDIT_W-1:0]  change_amount_q, change_amount_n;
    logic [IDX_W-1:0]     vend_item_q, vend_item_n;
    logic                 vend_valid_q, vend_valid_n;
    logic                 change_valid_q, change_valid_n;
    logic                 coin_reject_q, coin_reject_n;
    logic                 error_q, error_n;
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_n;
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_n [NUM_ITEMS];

    logic [CREDIT_W-1:0]  coin_val;
    logic [CREDIT_W:0]    coin_sum;
    logic [CREDIT_W-1:0]  sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    logic                 sel_in_range;
    logic                 sel_ok;
    logic                 tmo_hit;

`ifdef VM_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] tmr_q;

    // Down-counter reloads outside COLLECT and on any coin/selection; expiry at terminal count zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q != S_COLLECT || coin_valid || sel_valid) begin
            tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    assign tmo_hit = (tmr_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        coin_val     = COIN_VALUES[coin_sel*CREDIT_W +: CREDIT_W];
        coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
        sel_in_range = (int'(sel_item) < NUM_ITEMS);
        sel_price    = '0;
        sel_stock    = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(sel_item) == i) begin
                sel_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock_q[i];
            end
        end
        sel_ok = sel_in_range && (sel_stock != '0) && (credit_q >= sel_price);
    end

    always_comb begin
        state_n         = state_q;
        credit_n        = credit_q;
        change_amount_n = change_amount_q;
        vend_item_n     = vend_item_q;
        vend_valid_n    = 1'b0;
        change_valid_n  = change_valid_q;
        coin_reject_n   = 1'b0;
        error_n         = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_n[i] = stock_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    error_n = 1'b1;
                end
                if (coin_valid) begin
                    credit_n = coin_val;
                    state_n  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_n         = S_CHANGE;
                    change_valid_n  = 1'b1;
                    change_amount_n = credit_q;
                    coin_reject_n   = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_n = coin_valid;
                    if (sel_ok) begin
                        state_n      = S_DISPENSE;
                        vend_valid_n = 1'b1;
                        vend_item_n  = sel_item;
                        credit_n     = credit_q - sel_price;
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            if (int'(sel_item) == i) begin
                                stock_n[i] = stock_q[i] - STOCK_W'(1);
                            end
                        end
                    end else begin
                        error_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum[CREDIT_W]) begin
                        coin_reject_n = 1'b1;
                    end else begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                    end
                end else if (tmo_hit) begin
                    state_n         = S_CHANGE;
                    change_valid_n  = 1'b1;
                    change_amount_n = credit_q;
                end
            end
            S_DISPENSE: begin
                coin_reject_n = coin_valid;
                if (credit_q != '0) begin
                    state_n         = S_CHANGE;
                    change_valid_n  = 1'b1;
                    change_amount_n = credit_q;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_n = coin_valid;
                if (change_ack) begin
                    credit_n       = '0;
                    change_valid_n = 1'b0;
                    state_n        = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Restock is applied last so it overrides a same-cycle sale of the same item.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (restock_valid && int'(restock_item) == i) begin
                stock_n[i] = '1;
            end
            sold_out_n[i] = (stock_n[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            change_amount_q <= '0;
            vend_item_q     <= '0;
            vend_valid_q    <= 1'b0;
            change_valid_q  <= 1'b0;
            coin_reject_q   <= 1'b0;
            error_q         <= 1'b0;
            sold_out_q      <= {NUM_ITEMS{(STOCK_W'(INIT_STOCK) == '0)}};
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state_q         <= state_n;
            credit_q        <= credit_n;
            change_amount_q <= change_amount_n;
            vend_item_q     <= vend_item_n;
            vend_valid_q    <= vend_valid_n;
            change_valid_q  <= change_valid_n;
            coin_reject_q   <= coin_reject_n;
            error_q         <= error_n;
            sold_out_q      <= sold_out_n;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_n[i];
            end
        end
    end

    assign state         = state_q;
    assign credit        = credit_q;
    assign change_amount = change_amount_q;
    assign vend_item     = vend_item_q;
    assign vend_valid    = vend_valid_q;
    assign change_valid  = change_valid_q;
    assign coin_reject   = coin_reject_q;
    assign error         = error_q;
    assign sold_out      = sold_out_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: expected outputs are queued as each step is driven
// and checked one cycle later. Timeout branch follows VM_TIMEOUT_EN.
module tb_vend_ctrl_multi;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       restock_valid;
    logic [1:0] restock_item;
    logic       change_ack;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       error;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [7:0] cr;
        logic       vv;
        logic [1:0] vi;
        logic       cv;
        logic [7:0] ca;
        logic       rej;
        logic       err;
        logic [3:0] so;
    } exp_t;

    exp_t sb_q[$];

    vend_ctrl_multi #(
        .NUM_ITEMS      (4),
        .CREDIT_W       (8),
        .STOCK_W        (4),
        .ITEM_PRICES    ({8'd100, 8'd75, 8'd50, 8'd25}),
        .COIN_VALUES    ({8'd100, 8'd25, 8'd10, 8'd5}),
        .INIT_STOCK     (3),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_sel      (coin_sel),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .change_ack    (change_ack),
        .vend_valid    (vend_valid),
        .vend_item     (vend_item),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .coin_reject   (coin_reject),
        .error         (error),
        .credit        (credit),
        .sold_out      (sold_out),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [7:0] cr,
                        input logic vv, input logic [1:0] vi, input logic cv, input logic [7:0] ca,
                        input logic rej, input logic err, input logic [3:0] so);
        exp_t e;
        e.tag = tag; e.st = st; e.cr = cr; e.vv = vv; e.vi = vi;
        e.cv = cv; e.ca = ca; e.rej = rej; e.err = err; e.so = so;
        sb_q.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({e.tag, ".state"},   32'(state),        32'(e.st));
        chk({e.tag, ".credit"},  32'(credit),       32'(e.cr));
        chk({e.tag, ".vend_v"},  32'(vend_valid),   32'(e.vv));
        chk({e.tag, ".chg_v"},   32'(change_valid), 32'(e.cv));
        chk({e.tag, ".reject"},  32'(coin_reject),  32'(e.rej));
        chk({e.tag, ".error"},   32'(error),        32'(e.err));
        chk({e.tag, ".soldout"}, 32'(sold_out),     32'(e.so));
        if (e.vv) chk({e.tag, ".vend_item"}, 32'(vend_item), 32'(e.vi));
        if (e.cv) chk({e.tag, ".chg_amt"},   32'(change_amount), 32'(e.ca));
    endtask

    task automatic drive(input logic cv_i, input logic [1:0] cs, input logic sv, input logic [1:0] si,
                         input logic cn, input logic ak);
        coin_valid = cv_i; coin_sel = cs; sel_valid = sv; sel_item = si;
        cancel = cn; change_ack = ak;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        restock_valid = 1'b0;
        restock_item  = '0;
        compare_next();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        restock_valid = 1'b0;
        restock_item  = '0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        compare_next();
        chk("reset.vend_item", 32'(vend_item), 0);
        chk("reset.chg_amt", 32'(change_amount), 0);
        rst = 1'b0;

        // basic sale with an unaffordable selection first
        drive(1, 1, 0, 0, 0, 0); push("coin10",   1, 10, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("coin25",   1, 35, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 1, 0, 0); push("sel1_lo",  1, 35, 0, 0, 0, 0, 0, 1, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("coin25b",  1, 60, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 1, 0, 0); push("sel1_ok",  2, 10, 1, 1, 0, 0, 0, 0, 4'h0); step();
        push("change",   3, 10, 0, 0, 1, 10, 0, 0, 4'h0); step();
        push("chg_hold", 3, 10, 0, 0, 1, 10, 0, 0, 4'h0); step();
        drive(0, 0, 0, 0, 0, 1); push("ack",      0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        // idle-state behaviour
        drive(0, 0, 1, 0, 0, 0); push("idle_sel", 0, 0, 0, 0, 0, 0, 0, 1, 4'h0); step();
        drive(0, 0, 0, 0, 1, 1); push("idle_cn",  0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        // saturation boundary
        drive(1, 3, 0, 0, 0, 0); push("c100a", 1, 100, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 3, 0, 0, 0, 0); push("c100b", 1, 200, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("c25a",  1, 225, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("c25b",  1, 250, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 3, 0, 0, 0, 0); push("ovf100",1, 250, 0, 0, 0, 0, 1, 0, 4'h0); step();
        drive(1, 0, 0, 0, 0, 0); push("to255", 1, 255, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 0, 0, 0, 0, 0); push("ovf5",  1, 255, 0, 0, 0, 0, 1, 0, 4'h0); step();
        drive(0, 0, 0, 0, 1, 0); push("cn255", 3, 255, 0, 0, 1, 255, 0, 0, 4'h0); step();
        drive(0, 0, 0, 0, 0, 1); push("ack2",  0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        // cancel beats selection and coin in the same cycle
        drive(1, 2, 0, 0, 0, 0); push("c25c",   1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 0, 0, 0, 0, 0); push("c5c",    1, 30, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 1, 1, 0, 1, 0); push("triple", 3, 30, 0, 0, 1, 30, 1, 0, 4'h0); step();
        drive(1, 0, 0, 0, 0, 0); push("chg_cn", 3, 30, 0, 0, 1, 30, 1, 0, 4'h0); step();
        drive(0, 0, 0, 0, 0, 1); push("ack3",   0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        // sell out item0, refuse, restock
        drive(1, 2, 0, 0, 0, 0); push("b1_coin", 1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 0, 0, 0); push("b1_sel",  2, 0, 1, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 0, 0, 0, 0, 0); push("b1_rej",  0, 0, 0, 0, 0, 0, 1, 0, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("b2_coin", 1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 0, 0, 0); push("b2_sel",  2, 0, 1, 0, 0, 0, 0, 0, 4'h0); step();
        push("b2_idle", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(1, 2, 0, 0, 0, 0); push("b3_coin", 1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 0, 0, 0); push("b3_sel",  2, 0, 1, 0, 0, 0, 0, 0, 4'h1); step();
        push("b3_idle", 0, 0, 0, 0, 0, 0, 0, 0, 4'h1); step();
        drive(1, 2, 0, 0, 0, 0); push("b4_coin", 1, 25, 0, 0, 0, 0, 0, 0, 4'h1); step();
        drive(0, 0, 1, 0, 0, 0); push("b4_sel",  1, 25, 0, 0, 0, 0, 0, 1, 4'h1); step();
        restock_valid = 1'b1; restock_item = 2'd0;
        push("restock", 1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 1, 0, 0, 0); push("b5_sel",  2, 0, 1, 0, 0, 0, 0, 0, 4'h0); step();
        push("b5_idle", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        // asynchronous reset while change is pending
        drive(1, 2, 0, 0, 0, 0); push("r_coin", 1, 25, 0, 0, 0, 0, 0, 0, 4'h0); step();
        drive(0, 0, 0, 0, 1, 0); push("r_cn",   3, 25, 0, 0, 1, 25, 0, 0, 4'h0); step();
        rst = 1'b1;
        #2;
        push("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        compare_next();
        chk("async_rst.chg_amt", 32'(change_amount), 0);
        chk("async_rst.vend_item", 32'(vend_item), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // inactivity in COLLECT
        drive(1, 0, 0, 0, 0, 0); push("t_coin", 1, 5, 0, 0, 0, 0, 0, 0, 4'h0); step();
`ifdef VM_TIMEOUT_EN
        for (int i = 0; i < 19; i++) begin
            push("t_wait", 1, 5, 0, 0, 0, 0, 0, 0, 4'h0); step();
        end
        push("t_fire", 3, 5, 0, 0, 1, 5, 0, 0, 4'h0); step();
`else
        for (int i = 0; i < 25; i++) begin
            push("t_hold", 1, 5, 0, 0, 0, 0, 0, 0, 4'h0); step();
        end
        drive(0, 0, 0, 0, 1, 0); push("t_cn", 3, 5, 0, 0, 1, 5, 0, 0, 4'h0); step();
`endif
        drive(0, 0, 0, 0, 0, 1); push("t_ack", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0); step();

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending controller core: the multi-item successor of the fixed four-selection core. It accepts coin pulses of four configurable denominations and tracks credit with saturation protection. It keeps a per-item stock count, dispenses through one-cycle pulses, and returns change through a held valid/ack handshake. It sits between the board-level button synchroniser/edge detector and the LED or actuator drivers, in the divided-clock domain.

## Interface
- NUM_ITEMS, 4: number of products, ≥2.
- CREDIT_W, 8: credit and price width.
- STOCK_W, 4: per-item stock counter width.
- ITEM_PRICES, {8'd100,8'd75,8'd50,8'd25}: packed NUM_ITEMS×CREDIT_W.
  - Item i price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W].
  - Every price must be nonzero.
- COIN_VALUES, {8'd100,8'd25,8'd10,8'd5}: packed 4×CREDIT_W, indexed by coin_sel.
- INIT_STOCK, 3: stock of every item after reset.
- TIMEOUT_CYCLES, 1000: inactivity limit (used only with VM_TIMEOUT_EN).

Ports:
- clk  in  1  divided system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  one-cycle coin-insert pulse.
- coin_sel  in  2  denomination index.
- sel_valid  in  1  one-cycle selection pulse.
- sel_item  in  $clog2(NUM_ITEMS)  item index.
- cancel  in  1  one-cycle refund request.
- restock_valid  in  1  one-cycle restock pulse.
- restock_item  in  $clog2(NUM_ITEMS)  item to refill.
- change_ack  in  1  change consumer has taken change_amount.
- vend_valid  out  1  one-cycle dispense pulse.
- vend_item  out  $clog2(NUM_ITEMS)  dispensed item, valid with vend_valid.
- change_valid  out  1  change pending; held until acked.
- change_amount  out  CREDIT_W  refund value; stable while change_valid.
- coin_reject  out  1  one-cycle pulse: coin not credited, must be returned.
- error  out  1  one-cycle pulse: selection refused.
- credit  out  CREDIT_W  current credit.
- sold_out  out  NUM_ITEMS  bit i set when stock[i]==0.
- state  out  2  IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3.

## Operation
- All outputs are registered.
- Reset values:
  - state=IDLE; credit=0.
  - vend_valid, change_valid, coin_reject, error = 0.
  - vend_item=0; change_amount=0.
  - Every stock = INIT_STOCK; sold_out = 0 (all ones if INIT_STOCK=0).
- IDLE:
  - coin_valid: credit=coin value, go to COLLECT.
  - sel_valid: error pulse.
  - cancel: ignored.
- COLLECT, event priority cancel > sel_valid > coin_valid:
  - cancel: go to CHANGE (change_amount=credit).
  - sel_valid with stock 0, or credit < price: error pulse; stay; credit unchanged.
  - sel_valid accepted: go to DISPENSE; credit -= price; stock[item] -= 1; vend_item latched.
  - coin_valid:
    - credit += value.
    - If the sum would exceed 2^CREDIT_W−1, assert coin_reject instead and leave credit unchanged.
  - A coin that loses to cancel or sel_valid in the same cycle is rejected (coin_reject pulse).
- DISPENSE lasts exactly one cycle with vend_valid=1.
  - Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - change_valid=1 and change_amount=credit, held.
  - On change_ack: credit=0, change_valid=0, go to IDLE.
  - change_ack outside CHANGE is ignored.
- In DISPENSE or CHANGE, every coin_valid produces coin_reject; sel_valid and cancel are ignored.
- Restock:
  - Accepted in any state; sets stock[restock_item] to 2^STOCK_W−1.
  - Wins over a same-cycle decrement of the same item.
  - Out-of-range indices (NUM_ITEMS not a power of 2) are ignored for restock.
  - An out-of-range sel_item gives an error pulse.
- An rst assertion at any time, including mid-CHANGE, discards credit and returns to reset values asynchronously.

## Timing
- Coin credit: credit updated at the edge that samples coin_valid; visible the next cycle.
- Sale: sel_valid sampled at edge N → vend_valid high during cycle N+1 → change_valid high from N+2 (if credit>0).
- error and coin_reject: high for the single cycle after the offending input.
- change_ack sampled at edge M → change_valid low and state=IDLE from cycle M+1.
- Back-to-back events are accepted on consecutive cycles; there is no dead cycle in COLLECT.

## Configuration
- VM_TIMEOUT_EN defined:
  - A counter runs only in COLLECT and clears on any accepted or rejected coin, sel_valid, or entry into COLLECT.
  - After TIMEOUT_CYCLES idle cycles, the FSM goes to CHANGE exactly as for cancel.
- VM_TIMEOUT_EN undefined: no counter; COLLECT holds credit indefinitely.

## Test plan
- Reset, then coin_sel=1 (10) and coin_sel=2 (25), select item1 (50) → error, credit=35; add 25 → credit=60; select item1 → vend_valid/vend_item=1 one cycle later, change_valid with change_amount=10; ack → IDLE, credit=0.
- Credit 250 plus coin 100 → coin_reject pulse, credit stays 250.
- Same cycle: cancel, sel_valid, coin_valid with credit 30 → CHANGE, amount 30, coin_reject=1, no vend.
- Buy item0 three times (INIT_STOCK=3) → sold_out[0]=1; fourth attempt → error; restock item0 → stock 15, sold_out[0]=0.
- rst during CHANGE with change_valid=1 → all outputs at reset values immediately, without waiting for a clock edge.
- With VM_TIMEOUT_EN and TIMEOUT_CYCLES=20: coin 5, then no input → CHANGE entered 20 cycles later, amount 5; without the macro, state stays COLLECT.
